// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst read scheduler that drains NUM_Q latency-1 FIFOs into one tagged valid/ready stream.
// Define FIFO_RD_SCHED_PRIO_EN for strict fixed priority (lowest non-empty index always wins).
module fifo_rd_sched #(
  parameter int NUM_Q = 4,
  parameter int DWIDTH = 32,
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_Q-1:0] q_empty,
  output logic [NUM_Q-1:0] q_read,
  input  logic [NUM_Q*DWIDTH-1:0] q_dout,
  output logic out_valid,
  input  logic out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [$clog2(NUM_Q)-1:0] out_qid
);
  localparam int QW = $clog2(NUM_Q);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  logic [0:0] state;
  logic [QW-1:0] grant, winner, idx, inflight_qid;
  logic [7:0] bcnt;
  logic inflight, rd, credit_ok, push, pop, any_req;
  logic [1:0] count, wr_ptr, rd_ptr;
  logic [QW+DWIDTH-1:0] mem [3];
  assign any_req = ~&q_empty;
`ifdef FIFO_RD_SCHED_PRIO_EN
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      idx = QW'(i);
      if (!q_empty[idx]) winner = idx;
    end
  end
`else
  logic [QW-1:0] rr_last;
  // scan downwards so the nearest queue after rr_last overwrites the rest
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NUM_Q; k >= 1; k--) begin
      idx = QW'((int'(rr_last) + k) % NUM_Q);
      if (!q_empty[idx]) winner = idx;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n)
      rr_last <= QW'(NUM_Q - 1);
    else if (state == S_IDLE && any_req)
      rr_last <= winner;
`endif
  // a word in flight already owns a buffer slot; a same-cycle pop is not credited
  assign credit_ok = 3'(count) + 3'(inflight) < 3'd3;
  assign rd = state == S_BURST && !q_empty[grant] && credit_ok;
  assign q_read = rd ? NUM_Q'(1) << grant : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= '0;
      bcnt <= '0;
      inflight <= 1'b0;
      inflight_qid <= '0;
    end else begin
      inflight <= rd;
      if (rd)
        inflight_qid <= grant;
      if (state == S_IDLE) begin
        if (any_req) begin
          state <= S_BURST;
          grant <= winner;
          bcnt <= '0;
        end
      end else if (rd) begin
        bcnt <= bcnt + 8'd1;
        if (bcnt == 8'(BURST - 1))
          state <= S_IDLE;
      end else if (q_empty[grant])
        state <= S_IDLE;
    end
  assign push = inflight;
  assign out_valid = count != 2'd0;
  assign pop = out_valid && out_ready;
  assign {out_qid, out_data} = mem[rd_ptr];
  always_ff @(posedge clk)
    if (!rst_n) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 3; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {inflight_qid, q_dout[inflight_qid*DWIDTH +: DWIDTH]};
        wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: behavioural FIFO bank plus scoreboard for fifo_rd_sched.
// Expected streams come from a queue-level arbitration model; the monitor compares every accepted word.
module tb_fifo_rd_sched;
  localparam int NUM_Q = 4;
  localparam int DWIDTH = 32;
  localparam int BURST = 4;
  localparam int QW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b0;
  logic [NUM_Q-1:0] q_empty = '1;
  logic [NUM_Q-1:0] q_read;
  logic [NUM_Q*DWIDTH-1:0] q_dout = '0;
  logic out_valid;
  logic [DWIDTH-1:0] out_data;
  logic [QW-1:0] out_qid;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_total = 0;
  int fire_total = 0;
  bit strict = 1'b1;
  logic [DWIDTH-1:0] fq[NUM_Q][$];
  logic [DWIDTH-1:0] wq[NUM_Q][$];
  logic [DWIDTH-1:0] pq[NUM_Q][$];
  logic [QW+DWIDTH-1:0] exp_q[$];
  int fire_cyc[$];

  fifo_rd_sched #(.NUM_Q(NUM_Q), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_read(q_read), .q_dout(q_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_qid(out_qid)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic int pending();
    int n = exp_q.size();
    for (int i = 0; i < NUM_Q; i++)
      n += pq[i].size();
    return n;
  endfunction

  // latency-1 FIFO bank: staged writes become visible at the next edge
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NUM_Q; i++) begin
      if (q_read[i] === 1'b1 && fq[i].size() > 0) begin
        q_dout[i*DWIDTH +: DWIDTH] <= fq[i].pop_front();
        rd_total++;
      end
      while (wq[i].size() > 0)
        fq[i].push_back(wq[i].pop_front());
      q_empty[i] <= fq[i].size() == 0;
    end
  end

  always @(negedge clk)
    if (rst_n === 1'b1) begin
      chk("read_onehot_nonempty", {62'd0, $countones(q_read) <= 1, (q_read & q_empty) == '0}, 64'd3);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        fire_total++;
        fire_cyc.push_back(cyc);
        if (pq[out_qid].size() == 0) begin
          failures++;
          checks++;
          $display("FAIL unexpected_word qid=%0d data=%0h required=none", out_qid, out_data);
        end else
          chk($sformatf("q%0d_data", out_qid), 64'(out_data), 64'(pq[out_qid].pop_front()));
        if (strict) begin
          if (exp_q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL stream_extra actual=%0h required=none", {out_qid, out_data});
          end else
            chk("stream_order", 64'({out_qid, out_data}), 64'(exp_q.pop_front()));
        end
      end
    end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(int q, int n);
    logic [DWIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = $urandom;
      wq[q].push_back(d);
      pq[q].push_back(d);
    end
  endtask

  // queue-level model: everything loaded up front, scheduler freshly reset
  task automatic build_expected();
    int rem[NUM_Q];
    int pos[NUM_Q];
    int left;
    int w;
    int n;
`ifndef FIFO_RD_SCHED_PRIO_EN
    int last;
    last = NUM_Q - 1;
`endif
    left = 0;
    for (int i = 0; i < NUM_Q; i++) begin
      rem[i] = pq[i].size();
      pos[i] = 0;
      left += rem[i];
    end
    while (left > 0) begin
      w = -1;
`ifdef FIFO_RD_SCHED_PRIO_EN
      for (int i = 0; i < NUM_Q && w < 0; i++)
        if (rem[i] > 0) w = i;
`else
      for (int k = 1; k <= NUM_Q && w < 0; k++)
        if (rem[(last + k) % NUM_Q] > 0) w = (last + k) % NUM_Q;
      last = w;
`endif
      n = rem[w] < BURST ? rem[w] : BURST;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back({QW'(w), pq[w][pos[w]]});
        pos[w]++;
        rem[w]--;
        left--;
      end
    end
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain words_left=%0d required=0", name, pending());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    fire_cyc.delete();
  endtask

  initial begin
    logic [QW+DWIDTH:0] hold;
    #5_000_000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [QW+DWIDTH:0] hold;
    // reset with all queues loaded
    out_ready = 1'b1;
    for (int q = 0; q < NUM_Q; q++)
      load(q, 1);
    build_expected();
    tick(3);
    chk("reset_q_read", 64'(q_read), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    tick(3);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_qid", 64'(out_qid), 64'd0);
    drain("reset", 200);
    // single queue, bursts separated by one bubble
    do_reset();
    load(2, 10);
    build_expected();
    drain("q2", 500);
    chk("q2_count", 64'(fire_cyc.size()), 64'd10);
    for (int i = 1; i < fire_cyc.size(); i++)
      chk($sformatf("q2_gap%0d", i), 64'(fire_cyc[i] - fire_cyc[i-1]), (i % BURST == 0) ? 64'd2 : 64'd1);
    // all queues, round-robin (or priority) grant order
    do_reset();
    for (int q = 0; q < NUM_Q; q++)
      load(q, 8);
    build_expected();
    drain("all", 1000);
    // backpressure mid-burst
    do_reset();
    load(1, 12);
    build_expected();
    tick(6);
    out_ready = 1'b0;
    hold = {out_valid, out_qid, out_data};
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", 64'({out_valid, out_qid, out_data}), 64'(hold));
      chk("bp_buffered_le3", 64'(rd_total - fire_total <= 3), 64'd1);
    end
    chk("bp_q_read", 64'(q_read), 64'd0);
    out_ready = 1'b1;
    drain("bp", 500);
    // queue empties mid-burst, next queue takes over
    do_reset();
    load(1, 2);
    load(3, 3);
    build_expected();
    drain("short", 300);
    // random traffic, per-queue scoreboard only
    do_reset();
    strict = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int q = 0; q < NUM_Q; q++)
        if ($urandom_range(0, 99) < 8)
          load(q, 1);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    out_ready = 1'b1;
    drain("random", 5000);
    tick(5);
    chk("reads_eq_outputs", 64'(rd_total), 64'(fire_total));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
